// File: rtl/pic_pkg.sv
// -----------------------------------------------------------------------------
// pic_pkg
// Shared definitions for the 8259-compatible PIC write-side sequencer.
//   state_t      : initialisation / command sequencer states
//   bit indices  : ICW1 / OCW3 field positions used by the decode logic
// -----------------------------------------------------------------------------
package pic_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    W_ICW2 = 3'd1,
    W_ICW3 = 3'd2,
    W_ICW4 = 3'd3,
    READY  = 3'd4
  } state_t;

  // ICW1 field positions
  localparam int IC4       = 0;  // 1: an ICW4 write follows
  localparam int SNGL      = 1;  // 1: single PIC, 0: cascaded (ICW3 follows)
  localparam int ADI       = 2;  // call address interval (held, not decoded here)
  localparam int LTIM      = 3;  // level/edge trigger (held, not decoded here)
  // A0=0 write classification
  localparam int ICW1_FLAG = 4;  // D4=1 marks ICW1
  localparam int OCW3_FLAG = 3;  // with D4=0: D3=0 -> OCW2, D3=1 -> OCW3

endpackage

// File: rtl/icw_seq_fsm.sv
// -----------------------------------------------------------------------------
// icw_seq_fsm
// Purely combinational next-state and write-decode logic for the PIC
// write-side sequencer. The top level owns every register.
// Ports:
//   i_state       current sequencer state
//   i_wr_en       qualified write strobe
//   i_a0          address bit A0
//   i_icw1_flag   din[4] (ICW1 marker when A0=0)
//   i_ocw3_flag   din[3] (OCW2/OCW3 select when A0=0, D4=0)
//   i_ic4         latched ICW1.IC4
//   i_sngl        latched ICW1.SNGL
//   o_next_state  state for the next cycle
//   o_ld_icw1..4  load enables for the command word registers
//   o_ld_imr      OCW1 load enable
//   o_ocw2 / o_ocw3  OCW2 / OCW3 decoded this cycle
//   o_err         illegal write decoded this cycle
// -----------------------------------------------------------------------------
module icw_seq_fsm
  import pic_pkg::*;
(
  input  state_t i_state,
  input  logic   i_wr_en,
  input  logic   i_a0,
  input  logic   i_icw1_flag,
  input  logic   i_ocw3_flag,
  input  logic   i_ic4,
  input  logic   i_sngl,
  output state_t o_next_state,
  output logic   o_ld_icw1,
  output logic   o_ld_icw2,
  output logic   o_ld_icw3,
  output logic   o_ld_icw4,
  output logic   o_ld_imr,
  output logic   o_ocw2,
  output logic   o_ocw3,
  output logic   o_err
);

  always_comb begin
    o_next_state = i_state;
    o_ld_icw1    = 1'b0;
    o_ld_icw2    = 1'b0;
    o_ld_icw3    = 1'b0;
    o_ld_icw4    = 1'b0;
    o_ld_imr     = 1'b0;
    o_ocw2       = 1'b0;
    o_ocw3       = 1'b0;
    o_err        = 1'b0;
    if (i_wr_en) begin
      // ICW1 wins in every state and restarts the sequence.
      if (!i_a0 && i_icw1_flag) begin
        o_ld_icw1    = 1'b1;
        o_next_state = W_ICW2;
      end else begin
        unique case (i_state)
          IDLE: o_err = 1'b1;
          W_ICW2: begin
            if (i_a0) begin
              o_ld_icw2 = 1'b1;
              if (!i_sngl)    o_next_state = W_ICW3;
              else if (i_ic4) o_next_state = W_ICW4;
              else            o_next_state = READY;
            end else begin
              o_err = 1'b1;
            end
          end
          W_ICW3: begin
            if (i_a0) begin
              o_ld_icw3    = 1'b1;
              o_next_state = i_ic4 ? W_ICW4 : READY;
            end else begin
              o_err = 1'b1;
            end
          end
          W_ICW4: begin
            if (i_a0) begin
              o_ld_icw4    = 1'b1;
              o_next_state = READY;
            end else begin
              o_err = 1'b1;
            end
          end
          READY: begin
            if (i_a0)              o_ld_imr = 1'b1;
            else if (!i_ocw3_flag) o_ocw2   = 1'b1;
            else                   o_ocw3   = 1'b1;
          end
          default: o_next_state = IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/icw_init_sequencer.sv
// -----------------------------------------------------------------------------
// icw_init_sequencer
// Write-side command sequencer for the 8259-compatible PIC. Walks
// ICW1 -> ICW2 -> [ICW3] -> [ICW4], holds the command words, then decodes
// OCW1 (IMR), OCW2 and OCW3 writes. All outputs are registered.
// Optional feature macro: ICW_READBACK_EN (adds rd_sel / rd_data readback).
// Ports:
//   clk, rst_n        clock (rising edge), async active-low reset
//   wr_en, a0, din    qualified CPU write: strobe, A0, D7..D0
//   icw1..icw4        latched initialisation command words
//   imr               interrupt mask register
//   init_done         high while in READY
//   ocw2_wr, ocw3_wr  one-cycle strobes, payload on ocw_data
//   ocw_data          registered din captured on OCW2/OCW3
//   seq_error         one-cycle pulse on an illegal write
//   dbg_state         current sequencer state (pic_pkg::state_t encoding)
//   rd_sel, rd_data   (ICW_READBACK_EN only) {a0-tag, word} readback
// Handshake: wr_en is a plain strobe with no back-pressure; every cycle it is
// high is one write, and its effect is visible on the outputs one cycle later.
// -----------------------------------------------------------------------------
module icw_init_sequencer
  import pic_pkg::*;
#(
  parameter logic [7:0] ICW4_DEFAULT = 8'h00,
  parameter logic [7:0] IMR_INIT     = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic       a0,
  input  logic [7:0] din,
  output logic [7:0] icw1,
  output logic [7:0] icw2,
  output logic [7:0] icw3,
  output logic [7:0] icw4,
  output logic [7:0] imr,
  output logic       init_done,
  output logic       ocw2_wr,
  output logic       ocw3_wr,
  output logic [7:0] ocw_data,
  output logic       seq_error,
  output logic [2:0] dbg_state
`ifdef ICW_READBACK_EN
  ,
  input  logic [2:0] rd_sel,
  output logic [8:0] rd_data
`endif
);

  state_t     r_state;
  logic [7:0] r_icw1, r_icw2, r_icw3, r_icw4, r_imr, r_ocw_data;
  logic       r_init_done, r_ocw2_wr, r_ocw3_wr, r_seq_error;

  state_t w_next_state;
  logic   w_ld_icw1, w_ld_icw2, w_ld_icw3, w_ld_icw4, w_ld_imr;
  logic   w_ocw2, w_ocw3, w_err;

  icw_seq_fsm u_fsm (
    .i_state      (r_state),
    .i_wr_en      (wr_en),
    .i_a0         (a0),
    .i_icw1_flag  (din[ICW1_FLAG]),
    .i_ocw3_flag  (din[OCW3_FLAG]),
    .i_ic4        (r_icw1[IC4]),
    .i_sngl       (r_icw1[SNGL]),
    .o_next_state (w_next_state),
    .o_ld_icw1    (w_ld_icw1),
    .o_ld_icw2    (w_ld_icw2),
    .o_ld_icw3    (w_ld_icw3),
    .o_ld_icw4    (w_ld_icw4),
    .o_ld_imr     (w_ld_imr),
    .o_ocw2       (w_ocw2),
    .o_ocw3       (w_ocw3),
    .o_err        (w_err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_icw1      <= 8'h00;
      r_icw2      <= 8'h00;
      r_icw3      <= 8'h00;
      r_icw4      <= ICW4_DEFAULT;
      r_imr       <= IMR_INIT;
      r_ocw_data  <= 8'h00;
      r_init_done <= 1'b0;
      r_ocw2_wr   <= 1'b0;
      r_ocw3_wr   <= 1'b0;
      r_seq_error <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      // init_done tracks the registered state so it rises with the final ICW.
      r_init_done <= (w_next_state == READY);
      r_ocw2_wr   <= w_ocw2;
      r_ocw3_wr   <= w_ocw3;
      r_seq_error <= w_err;
      if (w_ld_icw1) begin
        r_icw1 <= din;
        r_icw4 <= ICW4_DEFAULT;
        r_imr  <= IMR_INIT;
      end
      if (w_ld_icw2) r_icw2 <= din;
      if (w_ld_icw3) r_icw3 <= din;
      if (w_ld_icw4) r_icw4 <= din;
      if (w_ld_imr)  r_imr  <= din;
      if (w_ocw2 || w_ocw3) r_ocw_data <= din;
    end
  end

  assign icw1      = r_icw1;
  assign icw2      = r_icw2;
  assign icw3      = r_icw3;
  assign icw4      = r_icw4;
  assign imr       = r_imr;
  assign init_done = r_init_done;
  assign ocw2_wr   = r_ocw2_wr;
  assign ocw3_wr   = r_ocw3_wr;
  assign ocw_data  = r_ocw_data;
  assign seq_error = r_seq_error;
  assign dbg_state = r_state;

`ifdef ICW_READBACK_EN
  logic [8:0] r_rd_data;

  // Tag bit mirrors the A0 value used to write the word (only ICW1 uses A0=0).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_data <= 9'h000;
    end else begin
      unique case (rd_sel)
        3'd0:    r_rd_data <= {1'b0, r_icw1};
        3'd1:    r_rd_data <= {1'b1, r_icw2};
        3'd2:    r_rd_data <= {1'b1, r_icw3};
        3'd3:    r_rd_data <= {1'b1, r_icw4};
        3'd4:    r_rd_data <= {1'b1, r_imr};
        default: r_rd_data <= 9'h000;
      endcase
    end
  end

  assign rd_data = r_rd_data;
`endif

endmodule

// File: tb/tb_icw_init_sequencer.sv
// -----------------------------------------------------------------------------
// tb_icw_init_sequencer
// Directed bench for icw_init_sequencer: ICW sequences (single/cascade,
// with/without ICW4), OCW decode, illegal writes, restart and async reset.
// Optional feature macro: ICW_READBACK_EN (connects and checks rd_sel/rd_data).
// -----------------------------------------------------------------------------
module tb_icw_init_sequencer;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_W_ICW2 = 3'd1;
  localparam logic [2:0] S_W_ICW3 = 3'd2;
  localparam logic [2:0] S_W_ICW4 = 3'd3;
  localparam logic [2:0] S_READY  = 3'd4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       wr_en = 1'b0;
  logic       a0 = 1'b0;
  logic [7:0] din = 8'h00;
  logic [7:0] icw1, icw2, icw3, icw4, imr, ocw_data;
  logic       init_done, ocw2_wr, ocw3_wr, seq_error;
  logic [2:0] dbg_state;
`ifdef ICW_READBACK_EN
  logic [2:0] rd_sel = 3'd0;
  logic [8:0] rd_data;
`endif

  icw_init_sequencer #(
    .ICW4_DEFAULT (8'h00),
    .IMR_INIT     (8'h00)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .a0        (a0),
    .din       (din),
    .icw1      (icw1),
    .icw2      (icw2),
    .icw3      (icw3),
    .icw4      (icw4),
    .imr       (imr),
    .init_done (init_done),
    .ocw2_wr   (ocw2_wr),
    .ocw3_wr   (ocw3_wr),
    .ocw_data  (ocw_data),
    .seq_error (seq_error),
    .dbg_state (dbg_state)
`ifdef ICW_READBACK_EN
    ,
    .rd_sel    (rd_sel),
    .rd_data   (rd_data)
`endif
  );

  // ---------------- scoreboard counters ----------------
  int pass_cnt = 0;
  int fail_cnt = 0;
  int total    = 0;

  task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // One-cycle write; returns at the following falling edge, after the
  // registered outputs have taken the write's effect.
  task automatic wr(input logic a, input logic [7:0] d);
    @(negedge clk);
    wr_en = 1'b1;
    a0    = a;
    din   = d;
    @(negedge clk);
    wr_en = 1'b0;
    a0    = 1'b0;
    din   = 8'h00;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_state"},     {6'd0, dbg_state}, {6'd0, S_IDLE});
    chk({tag, "_icw1"},      {1'b0, icw1},      9'h000);
    chk({tag, "_icw2"},      {1'b0, icw2},      9'h000);
    chk({tag, "_icw3"},      {1'b0, icw3},      9'h000);
    chk({tag, "_icw4"},      {1'b0, icw4},      9'h000);
    chk({tag, "_imr"},       {1'b0, imr},       9'h000);
    chk({tag, "_ocw_data"},  {1'b0, ocw_data},  9'h000);
    chk({tag, "_init_done"}, {8'd0, init_done}, 9'h000);
    chk({tag, "_ocw2_wr"},   {8'd0, ocw2_wr},   9'h000);
    chk({tag, "_ocw3_wr"},   {8'd0, ocw3_wr},   9'h000);
    chk({tag, "_seq_error"}, {8'd0, seq_error}, 9'h000);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    repeat (3) @(negedge clk);
    chk_reset_values("rst");
    rst_n = 1'b1;
    idle_cycle();

    // Single, IC4: ICW1=13, ICW2=48, ICW4=01 (W_ICW3 skipped)
    wr(1'b0, 8'h13);
    chk("t1_state_w2",   {6'd0, dbg_state}, {6'd0, S_W_ICW2});
    chk("t1_icw1",       {1'b0, icw1},      9'h013);
    chk("t1_init0",      {8'd0, init_done}, 9'h000);
    wr(1'b1, 8'h48);
    chk("t1_state_w4",   {6'd0, dbg_state}, {6'd0, S_W_ICW4});
    chk("t1_icw2",       {1'b0, icw2},      9'h048);
    chk("t1_init1",      {8'd0, init_done}, 9'h000);
    wr(1'b1, 8'h01);
    chk("t1_state_rdy",  {6'd0, dbg_state}, {6'd0, S_READY});
    chk("t1_init2",      {8'd0, init_done}, 9'h001);
    chk("t1_icw4",       {1'b0, icw4},      9'h001);
    chk("t1_icw3",       {1'b0, icw3},      9'h000);

    // READY: OCW1 / OCW2 / OCW3
    wr(1'b1, 8'hF0);
    chk("ocw1_imr",      {1'b0, imr},       9'h0F0);
    chk("ocw1_no_o2",    {8'd0, ocw2_wr},   9'h000);
    wr(1'b0, 8'h20);
    chk("ocw2_pulse",    {8'd0, ocw2_wr},   9'h001);
    chk("ocw2_no_o3",    {8'd0, ocw3_wr},   9'h000);
    chk("ocw2_data",     {1'b0, ocw_data},  9'h020);
    chk("ocw2_imr_hold", {1'b0, imr},       9'h0F0);
    idle_cycle();
    chk("ocw2_pulse_end",{8'd0, ocw2_wr},   9'h000);
    chk("hold_data",     {1'b0, ocw_data},  9'h020);
    wr(1'b0, 8'h0B);
    chk("ocw3_pulse",    {8'd0, ocw3_wr},   9'h001);
    chk("ocw3_no_o2",    {8'd0, ocw2_wr},   9'h000);
    chk("ocw3_data",     {1'b0, ocw_data},  9'h00B);
    chk("ocw3_state",    {6'd0, dbg_state}, {6'd0, S_READY});
    idle_cycle();
    chk("ocw3_pulse_end",{8'd0, ocw3_wr},   9'h000);

    // Single, no IC4: ICW1=1A, ICW2=08 -> READY, icw4 default
    wr(1'b0, 8'h1A);
    chk("t3_imr_init",   {1'b0, imr},       9'h000);
    chk("t3_state_w2",   {6'd0, dbg_state}, {6'd0, S_W_ICW2});
    chk("t3_init0",      {8'd0, init_done}, 9'h000);
    chk("t3_icw4_def",   {1'b0, icw4},      9'h000);
    wr(1'b1, 8'h08);
    chk("t3_state_rdy",  {6'd0, dbg_state}, {6'd0, S_READY});
    chk("t3_init1",      {8'd0, init_done}, 9'h001);
    chk("t3_icw2",       {1'b0, icw2},      9'h008);
    chk("t3_icw4",       {1'b0, icw4},      9'h000);

    // Illegal write in W_ICW2, then restart via ICW1
    wr(1'b1, 8'h55);
    chk("imr_55",        {1'b0, imr},       9'h055);
    wr(1'b0, 8'h11);
    chk("err_state_w2",  {6'd0, dbg_state}, {6'd0, S_W_ICW2});
    chk("err_imr_init",  {1'b0, imr},       9'h000);
    wr(1'b0, 8'h0A);
    chk("err_pulse",     {8'd0, seq_error}, 9'h001);
    chk("err_state_hold",{6'd0, dbg_state}, {6'd0, S_W_ICW2});
    chk("err_no_ocw2",   {8'd0, ocw2_wr},   9'h000);
    idle_cycle();
    chk("err_pulse_end", {8'd0, seq_error}, 9'h000);
    wr(1'b0, 8'h1B);
    chk("restart_state", {6'd0, dbg_state}, {6'd0, S_W_ICW2});
    chk("restart_icw1",  {1'b0, icw1},      9'h01B);
    chk("restart_imr",   {1'b0, imr},       9'h000);
    chk("restart_noerr", {8'd0, seq_error}, 9'h000);

    // Cascade, IC4: ICW1=11, ICW2=20, ICW3=04, ICW4=1D
    wr(1'b0, 8'h11);
    wr(1'b1, 8'h20);
    chk("t2_state_w3",   {6'd0, dbg_state}, {6'd0, S_W_ICW3});
    chk("t2_icw2",       {1'b0, icw2},      9'h020);
    wr(1'b1, 8'h04);
    chk("t2_state_w4",   {6'd0, dbg_state}, {6'd0, S_W_ICW4});
    chk("t2_icw3",       {1'b0, icw3},      9'h004);
    chk("t2_init0",      {8'd0, init_done}, 9'h000);
    wr(1'b1, 8'h1D);
    chk("t2_state_rdy",  {6'd0, dbg_state}, {6'd0, S_READY});
    chk("t2_init1",      {8'd0, init_done}, 9'h001);
    chk("t2_icw4",       {1'b0, icw4},      9'h01D);
    chk("t2_icw1",       {1'b0, icw1},      9'h011);

    // wr_en held two cycles in READY = two OCW2 writes
    @(negedge clk);
    wr_en = 1'b1; a0 = 1'b0; din = 8'h60;
    @(negedge clk);
    chk("hold_w1_pulse", {8'd0, ocw2_wr},   9'h001);
    chk("hold_w1_data",  {1'b0, ocw_data},  9'h060);
    din = 8'h67;
    @(negedge clk);
    wr_en = 1'b0; din = 8'h00;
    chk("hold_w2_pulse", {8'd0, ocw2_wr},   9'h001);
    chk("hold_w2_data",  {1'b0, ocw_data},  9'h067);

    // Reset in W_ICW3 discards the partial sequence
    wr(1'b0, 8'h11);
    wr(1'b1, 8'h48);
    chk("rst_pre_state", {6'd0, dbg_state}, {6'd0, S_W_ICW3});
`ifdef ICW_READBACK_EN
    rd_sel = 3'd1;
    idle_cycle();
    idle_cycle();
    chk("rdback_icw2",   rd_data,           9'h148);
    rd_sel = 3'd0;
    idle_cycle();
    idle_cycle();
    chk("rdback_icw1",   rd_data,           9'h011);
`endif
    #1 rst_n = 1'b0;
    #1;
    chk_reset_values("midrst");
`ifdef ICW_READBACK_EN
    chk("midrst_rd_data", rd_data,          9'h000);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    idle_cycle();

    // IDLE: non-ICW1 write is an error and changes nothing
    wr(1'b1, 8'h33);
    chk("idle_err",      {8'd0, seq_error}, 9'h001);
    chk("idle_state",    {6'd0, dbg_state}, {6'd0, S_IDLE});
    chk("idle_icw2",     {1'b0, icw2},      9'h000);
    chk("idle_imr",      {1'b0, imr},       9'h000);

    idle_cycle();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/icw_init_sequencer.md
Name: icw_init_sequencer

Overview:
- Write-side command sequencer for the 8259-compatible PIC.
- Accepts CPU writes qualified by A0 and the data bus.
- Walks the ICW1 → ICW2 → [ICW3] → [ICW4] initialisation sequence and holds the resulting command words for the priority/cascade datapath.
- After initialisation, decodes OCW1/OCW2/OCW3 writes: latches the IMR and issues one-cycle OCW strobes.

Parameters:
- ICW4_DEFAULT, 8'h00, value loaded into icw4 when ICW1.IC4=0.
- IMR_INIT, 8'h00, IMR value on reset and on every ICW1 write.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- wr_en  in  1  one-cycle write strobe, already qualified by chip select.
- a0  in  1  address bit A0 of the write.
- din  in  8  write data D7..D0.
- icw1  out  8  latched ICW1 (D7..D0).
- icw2  out  8  latched ICW2; [7:3]=T7..T3 vector base.
- icw3  out  8  latched ICW3 (master slave-map or slave ID).
- icw4  out  8  latched ICW4 or ICW4_DEFAULT.
- imr  out  8  interrupt mask register (OCW1).
- init_done  out  1  high in READY state.
- ocw2_wr  out  1  one-cycle pulse, OCW2 written; payload on ocw_data.
- ocw3_wr  out  1  one-cycle pulse, OCW3 written; payload on ocw_data.
- ocw_data  out  8  registered copy of din for OCW2/OCW3 strobes.
- seq_error  out  1  one-cycle pulse on an illegal write during initialisation.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - icw1..icw3=0, icw4=ICW4_DEFAULT, imr=IMR_INIT, ocw_data=0.
  - All pulses and init_done = 0.
- States: IDLE, W_ICW2, W_ICW3, W_ICW4, READY.
- ICW1 write (wr_en & ~a0 & din[4]):
  - Accepted in every state, including mid-sequence; restarts the sequence.
  - Next cycle: icw1=din, icw4=ICW4_DEFAULT, imr=IMR_INIT, init_done=0, state=W_ICW2.
- W_ICW2:
  - a0=1 write latches icw2.
  - Next state: if icw1[1]=0 (cascade), W_ICW3; else if icw1[0]=1 (IC4), W_ICW4; else READY.
- W_ICW3:
  - a0=1 write latches icw3.
  - Next state: W_ICW4 if IC4, else READY.
- W_ICW4:
  - a0=1 write latches icw4.
  - Next state: READY.
- In W_ICW2/W_ICW3/W_ICW4, a write with a0=0 & din[4]=0: ignored, state held, seq_error pulses the next cycle.
- IDLE: any non-ICW1 write → seq_error pulse, state held.
- READY:
  - a0=1: imr=din (OCW1).
  - a0=0, din[4:3]=00: ocw2_wr=1, ocw_data=din.
  - a0=0, din[4:3]=01: ocw3_wr=1, ocw_data=din.
- Latency: all outputs are registered, one cycle after the wr_en edge. init_done rises in the same cycle the final ICW lands.
- Pulses are exactly one cycle. wr_en held high for N cycles is treated as N writes.
- When wr_en=0, all outputs hold.
- Reset mid-sequence returns to IDLE with all reset values; partial ICWs are discarded.

Optional Feature:
- Macro: ICW_READBACK_EN.
- When defined:
  - Adds input rd_sel[2:0] and registered output rd_data[8:0].
  - Each cycle rd_data={a0-tag, word}: 0=icw1 (tag 0), 1=icw2 (tag 1), 2=icw3 (tag 1), 3=icw4 (tag 1), 4=imr (tag 1), others 9'h000.
  - rd_data resets to 0.
- When undefined: ports absent, no readback logic.

Decomposition:
- Shared package pic_pkg:
  - state enum {IDLE, W_ICW2, W_ICW3, W_ICW4, READY}.
  - Bit-index constants IC4=0, SNGL=1, ADI=2, LTIM=3, ICW1_FLAG=4, OCW3_FLAG=3.
- Sub-module icw_seq_fsm holds the next-state and write-decode logic. The top level holds the registers.

Test Plan:
- ICW1=8'h13 (single, IC4), ICW2=8'h48, ICW4=8'h01 → state skips W_ICW3; init_done=1 one cycle after the ICW4 write; icw2=8'h48, icw4=8'h01, icw3=8'h00.
- ICW1=8'h11 (cascade, IC4), ICW2=8'h20, ICW3=8'h04, ICW4=8'h1D → all four latched; init_done only after the 4th write.
- ICW1=8'h1A (single, no IC4), ICW2=8'h08 → READY after the 2nd write; icw4=ICW4_DEFAULT.
- In READY, write a0=1 din=8'hF0 → imr=8'hF0. Write a0=0 din=8'h20 → ocw2_wr pulse, ocw_data=8'h20. Write a0=0 din=8'h0B → ocw3_wr pulse.
- In W_ICW2, write a0=0 din=8'h0A → seq_error pulse, state W_ICW2. Then write a0=0 din=8'h1B → restart, imr=IMR_INIT, still W_ICW2.
- Assert rst_n=0 while in W_ICW3 → immediately all outputs at reset values and state IDLE. With ICW_READBACK_EN, rd_sel=1 after ICW2=8'h48 → rd_data=9'h148.
